window_dot_engine: RTL and testbench

//   Parametrised successor to the single-shot byte shift/sum/product datapath.
//   Two DEPTH-deep sample windows (A, B) fill from a streaming input. On start, a

---
 rtl/wde_pkg.sv | 16 +
 rtl/window_shift_buf.sv | 44 ++++
 rtl/window_dot_engine.sv | 137 +++++++++++++
 tb/tb_window_dot_engine.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wde_pkg.sv
// Shared constants and types for the window dot engine.
package wde_pkg;

  // Reduction selectors, latched when a computation is accepted.
  localparam logic [1:0] MODE_DOT = 2'b00;
  localparam logic [1:0] MODE_SUM = 2'b01;
  localparam logic [1:0] MODE_SAD = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

endpackage

// File: rtl/window_shift_buf.sv
// DEPTH-deep sample window: newest sample at index 0, oldest drops out.
// Tracks how many samples have arrived (saturating) and offers a random read port.
module window_shift_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       clear,
  input  logic                       shift,
  input  logic [W-1:0]               din,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [W-1:0]               rd_data,
  output logic                       full
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [W-1:0]      win [DEPTH];
  logic [FILL_W-1:0] fill;

  // Shift register plus saturating fill count; clear wins over shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      fill <= '0;
    end else if (ena) begin
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) win[i] <= '0;
        fill <= '0;
      end else if (shift) begin
        win[0] <= din;
        for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
    end
  end

  assign rd_data = win[rd_idx];
  assign full    = (fill == FILL_MAX);

endmodule

// File: rtl/window_dot_engine.sv
// Two sample windows feeding a one-term-per-cycle reduction engine (dot, sum, SAD);
// the accumulated result leaves LSB byte first over a valid/ready handshake.
module window_dot_engine
  import wde_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int ACC_W = 2*W + $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] sample_a,
  input  logic [W-1:0] sample_b,
  input  logic [1:0]   mode,
  input  logic         start,
  output logic         full,
  output logic         busy,
  output logic         in_drop,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic         out_last
);

  localparam int NBYTES = (ACC_W + 7) / 8;
  localparam int OUT_W  = 8 * NBYTES;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DEPTH - 1);
  localparam logic [BI_W-1:0]  BYTE_LAST = BI_W'(NBYTES - 1);

  state_t                   state;
  logic [1:0]               mode_q;
  logic [IDX_W-1:0]         idx;
  logic [BI_W-1:0]          byte_idx;
  logic signed [ACC_W-1:0]  acc;

  logic                     full_a, full_b, shift;
  logic signed [W-1:0]      rd_a, rd_b;
  logic signed [ACC_W-1:0]  a_x, b_x, diff, abs_diff, term;
  logic signed [2*W-1:0]    prod;
  logic signed [OUT_W-1:0]  res_ext;

  // Samples only enter the windows while idle; clear flushes them instead.
  assign shift = in_valid && (state == IDLE) && !clear;

  window_shift_buf #(.W(W), .DEPTH(DEPTH)) u_win_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .shift(shift),
    .din(sample_a), .rd_idx(idx), .rd_data(rd_a), .full(full_a)
  );

  window_shift_buf #(.W(W), .DEPTH(DEPTH)) u_win_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .shift(shift),
    .din(sample_b), .rd_idx(idx), .rd_data(rd_b), .full(full_b)
  );

  // Both windows always shift together, so their fill state is identical.
  assign full = full_a && full_b;

  // Per-index term, sign-extended into the accumulator width.
  always_comb begin
    prod     = (2*W)'(rd_a) * (2*W)'(rd_b);
    a_x      = ACC_W'(rd_a);
    b_x      = ACC_W'(rd_b);
    diff     = a_x - b_x;
    abs_diff = diff[ACC_W-1] ? -diff : diff;
    term     = '0;
    case (mode_q)
      MODE_DOT: term = ACC_W'(prod);
      MODE_SUM: term = a_x + b_x;
      MODE_SAD: term = abs_diff;
      MODE_RSV: term = '0;
    endcase
  end

  // Control FSM, accumulator and output byte pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= MODE_DOT;
      idx       <= '0;
      byte_idx  <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        state     <= IDLE;
        idx       <= '0;
        byte_idx  <= '0;
        acc       <= '0;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // full is the pre-shift value, so a same-cycle 8th sample cannot enable start.
            if (start && full) begin
              mode_q <= mode;
              acc    <= '0;
              idx    <= '0;
              state  <= COMPUTE;
            end
          end
          COMPUTE: begin
            acc <= acc + term;
            idx <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              state     <= OUTPUT;
              out_valid <= 1'b1;
              byte_idx  <= '0;
            end
          end
          OUTPUT: begin
            if (out_ready) begin
              if (byte_idx == BYTE_LAST) begin
                state     <= IDLE;
                out_valid <= 1'b0;
              end else begin
                byte_idx <= byte_idx + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy     = (state != IDLE);
  assign in_drop  = ena && in_valid && busy && !clear;
  assign res_ext  = OUT_W'(acc);
  assign out_byte = 8'(res_ext >> {byte_idx, 3'b000});
  assign out_last = out_valid && (byte_idx == BYTE_LAST);

endmodule

// File: tb/tb_window_dot_engine.sv
// Directed + randomized bench for window_dot_engine with a queue-based reference model.
module tb_window_dot_engine;

  localparam int W      = 8;
  localparam int DEPTH  = 8;
  localparam int NBYTES = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] sample_a = '0;
  logic [7:0] sample_b = '0;
  logic [1:0] mode = '0;
  logic       start = 1'b0;
  logic       full, busy, in_drop, out_valid, out_last;
  logic       out_ready = 1'b1;
  logic [7:0] out_byte;

  int n_assert = 0;
  int n_fail   = 0;
  int qa[$];
  int qb[$];

  window_dot_engine #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .in_valid(in_valid),
    .sample_a(sample_a), .sample_b(sample_b), .mode(mode), .start(start),
    .full(full), .busy(busy), .in_drop(in_drop), .out_valid(out_valid),
    .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_push(input int a, input int b);
    qa.push_front(a);
    qb.push_front(b);
    if (qa.size() > DEPTH) begin
      void'(qa.pop_back());
      void'(qb.pop_back());
    end
  endfunction

  function automatic int model_result(input logic [1:0] m);
    int r = 0;
    for (int i = 0; i < DEPTH; i++) begin
      case (m)
        2'b00: r += qa[i] * qb[i];
        2'b01: r += qa[i] + qb[i];
        2'b10: r += (qa[i] > qb[i]) ? (qa[i] - qb[i]) : (qb[i] - qa[i]);
        default: r += 0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input int r, input int k);
    logic [31:0] rv;
    rv = r;
    return rv[8*k +: 8];
  endfunction

  task automatic push(input int a, input int b);
    in_valid = 1'b1;
    sample_a = 8'(a);
    sample_b = 8'(b);
    step();
    in_valid = 1'b0;
    model_push(a, b);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    qa.delete();
    qb.delete();
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Start, optionally poke in_valid mid-compute (with one frozen cycle first),
  // check latency and the full byte stream against the model.
  task automatic run_and_check(input logic [1:0] m, input string tag, input bit inject);
    int r, cyc, exp_cyc;
    r = model_result(m);
    exp_cyc = DEPTH + 1 + (inject ? 1 : 0);
    mode  = m;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 1;
    if (inject) begin
      ena = 1'b0;
      in_valid = 1'b1;
      sample_a = 8'($urandom);
      sample_b = 8'($urandom);
      #1;
      check({tag, "_drop_frozen"}, 32'(in_drop), 32'd0);
      step();
      cyc++;
      ena = 1'b1;
      #1;
      check({tag, "_drop"}, 32'(in_drop), 32'd1);
      step();
      cyc++;
      in_valid = 1'b0;
    end
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    for (int k = 0; k < NBYTES; k++) begin
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_byte"}, 32'(out_byte), 32'(exp_byte(r, k)));
      check({tag, "_last"}, 32'(out_last), 32'(k == NBYTES - 1));
      step();
    end
    check({tag, "_idle"}, 32'({busy, out_valid}), 32'd0);
  endtask

  initial begin
    int r, cyc;
    logic [1:0] m;

    #12;
    check("rst_outputs", 32'({full, busy, in_drop, out_valid, out_last}), 32'd0);
    check("rst_byte", 32'(out_byte), 32'd0);
    rst_n = 1'b1;
    step();

    // Dot product, a=1..8, b=2
    for (int i = 1; i <= DEPTH; i++) push(i, 2);
    check("dot_full", 32'(full), 32'd1);
    run_and_check(2'b00, "dot", 1'b0);

    // Signed dot, a=-1, b=127
    for (int i = 0; i < DEPTH; i++) push(-1, 127);
    run_and_check(2'b00, "sdot", 1'b0);

    // Sum then SAD
    for (int i = 1; i <= DEPTH; i++) push(i, 2);
    run_and_check(2'b01, "sum", 1'b0);
    for (int i = 0; i < DEPTH; i++) push(10, -6);
    run_and_check(2'b10, "sad", 1'b0);

    // Start rejected below full; 8th sample arriving with start still rejected
    do_clear();
    check("clr_full", 32'(full), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) push(rnd_sample(), rnd_sample());
    start = 1'b1;
    step();
    start = 1'b0;
    check("fill7_start_busy", 32'(busy), 32'd0);
    start = 1'b1;
    r = rnd_sample();
    push(r, rnd_sample());
    start = 1'b0;
    check("same_cycle_busy", 32'(busy), 32'd0);
    check("same_cycle_full", 32'(full), 32'd1);
    run_and_check(2'b00, "fill8", 1'b0);

    // Dropped sample mid-compute, then repeat gives identical result
    run_and_check(2'b10, "drop", 1'b1);
    run_and_check(2'b10, "repeat", 1'b0);

    // Randomized windows and modes, including reserved
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < DEPTH; i++) push(rnd_sample(), rnd_sample());
      m = (t == 5) ? 2'b11 : 2'($urandom_range(0, 3));
      run_and_check(m, "rand", 1'b0);
    end

    // Backpressure on byte 1, then clear mid-output
    for (int i = 0; i < DEPTH; i++) push(rnd_sample(), rnd_sample());
    m = 2'b00;
    r = model_result(m);
    out_ready = 1'b0;
    mode = m;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
    check("bp_latency", 32'(cyc), 32'(DEPTH + 1));
    check("bp_byte0", 32'(out_byte), 32'(exp_byte(r, 0)));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_byte", 32'(out_byte), 32'(exp_byte(r, 1)));
      check("bp_hold_valid", 32'({out_valid, out_last}), 32'b10);
      step();
    end
    do_clear();
    check("bp_clear_valid", 32'(out_valid), 32'd0);
    check("bp_clear_full", 32'(full), 32'd0);
    check("bp_clear_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;

    // After clear the windows hold zeros: 7 pushes leave one zero slot... refill fully
    for (int i = 0; i < DEPTH; i++) push(rnd_sample(), rnd_sample());
    run_and_check(2'b01, "post_clear", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
